fft_seq_ctrl: RTL and testbench

- Sequences a radix-2 decimation-in-time FFT of N = 2^LOG2N points through the single floating-point butterfly core, `fft_core`.
- `fft_core` computes one output per pass: X + W·Y.
- Each butterfly therefore takes two passes:
  - pass A with W, producing the top output;
  - pass B with −W, producing the bottom output.
- Sits between the sample/twiddle memories and `fft_core`:
  - generates read, write and twiddle addresses;
  - drives the core enables and the per-pass strobes (issue strobe and add strobe);
  - selects the ping-pong memory bank, one bank per stage.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_wb_pipe.sv | 47 ++++
 rtl/fft_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and address math for the radix-2 DIT FFT sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pass A uses +W and writes the top output, pass B uses -W and writes the bottom one.
    localparam logic PASS_A = 1'b0;
    localparam logic PASS_B = 1'b1;

    // Widest supported transform; address fields are sized for it and cut down by the user.
    localparam int MAX_LOG2N = 10;

    typedef struct packed {
        logic [MAX_LOG2N-1:0] top;
        logic [MAX_LOG2N-1:0] bot;
        logic [MAX_LOG2N-1:0] tw;
    } bfly_addr_t;

    // Operand and twiddle addresses of butterfly b in stage s of a 2^log2n point transform.
    function automatic bfly_addr_t bfly_addr(input int s, input int b, input int log2n);
        int         half;
        int         pos;
        int         top;
        bfly_addr_t a;
        half  = 1 << s;
        pos   = b & (half - 1);
        top   = ((b >> s) << (s + 1)) | pos;
        a.top = MAX_LOG2N'(top);
        a.bot = MAX_LOG2N'(top + half);
        a.tw  = MAX_LOG2N'(pos << (log2n - 1 - s));
        return a;
    endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// LAT-deep delay line carrying {valid, destination} from issue to write-back.
module fft_wb_pipe #(
    parameter int LAT = 6,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          pending
);

    logic [LAT-1:0] vld_q;
    logic [AW-1:0]  addr_q [LAT];

    // Shift one stage per cycle; clear drops every in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            // NOTE: the address lanes are reset too because they drive wr_addr directly, which must read 0 out of reset.
            for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else if (clear) begin
            vld_q <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            addr_q[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_addr  = addr_q[LAT-1];

    // Writes still behind the output stage; zero means the current out_valid is the last one.
    if (LAT > 1) begin : g_pending
        assign pending = |vld_q[LAT-2:0];
    end else begin : g_no_pending
        assign pending = 1'b0;
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Address/strobe sequencer driving one butterfly core through an in-place ping-pong FFT.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int LAT   = 6,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             ena_fft_core,
    output logic             ena_mul_fp_clk,
    output logic             ena_add_fp_clk,
    output logic [LOG2N-1:0] rd_addr_x,
    output logic [LOG2N-1:0] rd_addr_y,
    output logic [LOG2N-2:0] tw_addr,
    output logic             w_neg,
    output logic             rd_bank,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr,
    output logic             busy,
    output logic             done
);

    localparam int N      = 1 << LOG2N;
    localparam int HALF_N = N / 2;
    localparam int SW     = $clog2(LOG2N);
    localparam int BW     = LOG2N - 1;
    localparam int TW     = LOG2N - 1;
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [BW-1:0]   bfly;
    logic            pass;
    logic [GW-1:0]   slot;

    logic [SW-1:0]   iss_stage;
    logic [BW-1:0]   iss_bfly;
    logic            iss_pass;
    bfly_addr_t      iss_addr;
    logic            slot_end;
    logic            last_issue;
    logic            last_stage;
    logic            abort_hit;
    logic            issue_now;
    logic            pipe_pending;
    logic [LOG2N-1:0] wb_dest;

    assign slot_end   = (slot == GW'(GAP - 1));
    assign last_issue = (pass == PASS_B) && (bfly == BW'(HALF_N - 1));
    assign last_stage = (stage == SW'(LOG2N - 1));
    assign abort_hit  = abort && (state != IDLE);

    // Coordinates and addresses of the pass that would be issued next.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        iss_stage = stage;
        iss_bfly  = bfly;
        iss_pass  = PASS_A;
        issue_now = 1'b0;
        case (state)
            IDLE: begin
                iss_stage = '0;
                iss_bfly  = '0;
                issue_now = start;
            end
            DRAIN: begin
                iss_stage = stage + 1'b1;
                iss_bfly  = '0;
                issue_now = !pipe_pending && !last_stage;
            end
            ISSUE: begin
                if (pass == PASS_A) iss_pass = PASS_B;
                else                iss_bfly = bfly + 1'b1;
                issue_now = slot_end && !last_issue;
            end
            default: ;
        endcase
        iss_addr = bfly_addr(int'(iss_stage), int'(iss_bfly), LOG2N);
    end

    // Main FSM with registered outputs; abort beats every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            stage          <= '0;
            bfly           <= '0;
            pass           <= PASS_A;
            slot           <= '0;
            ena_fft_core   <= 1'b0;
            ena_mul_fp_clk <= 1'b0;
            rd_addr_x      <= '0;
            rd_addr_y      <= '0;
            tw_addr        <= '0;
            w_neg          <= 1'b0;
            rd_bank        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (abort_hit) begin
            state          <= IDLE;
            slot           <= '0;
            ena_fft_core   <= 1'b0;
            ena_mul_fp_clk <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later <= in the same block overrides the default above it.
            ena_mul_fp_clk <= issue_now;
            done           <= 1'b0;
            if (issue_now) begin
                stage     <= iss_stage;
                bfly      <= iss_bfly;
                pass      <= iss_pass;
                slot      <= '0;
                rd_addr_x <= LOG2N'(iss_addr.top);
                rd_addr_y <= LOG2N'(iss_addr.bot);
                tw_addr   <= TW'(iss_addr.tw);
                w_neg     <= iss_pass;
            end else if (state == ISSUE) begin
                slot <= slot_end ? '0 : slot + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        ena_fft_core <= 1'b1;
                        rd_bank      <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (slot_end && last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_pending) begin
                        if (last_stage) begin
                            state        <= DONE;
                            ena_fft_core <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            rd_bank <= ~rd_bank;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Adder strobe trails the multiplier strobe by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ena_add_fp_clk <= 1'b0;
        else        ena_add_fp_clk <= ena_mul_fp_clk;
    end

    // Pass A lands on the top element, pass B on the bottom one.
    assign wb_dest = w_neg ? rd_addr_y : rd_addr_x;

    fft_wb_pipe #(
        .LAT (LAT),
        .AW  (LOG2N)
    ) u_wb_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort_hit),
        .in_valid  (ena_mul_fp_clk),
        .in_addr   (wb_dest),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .pending   (pipe_pending)
    );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: 8-point transforms, abort, async reset, GAP=LAT=1 corner.
module tb_fft_seq_ctrl;

    localparam int BIG = 1 << 30;

    typedef struct {
        int cyc;
        int x;
        int y;
        int tw;
        int wneg;
        int bank;
    } iss_t;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    // Hand-computed butterfly operands for N=8: [stage][butterfly].
    int tx [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int ty [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int ttw[3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1, abort0, abort1;
    logic sel;

    logic core0, mul0, add0, wneg0, bank0, wr0, busy0, done0;
    logic [2:0] x0, y0, wa0;
    logic [1:0] tw0;
    logic core1, mul1, add1, wneg1, bank1, wr1, busy1, done1;
    logic [2:0] x1, y1, wa1;
    logic [1:0] tw1;

    logic m_core, m_mul, m_add, m_wneg, m_bank, m_wr, m_busy, m_done;
    logic [2:0] m_x, m_y, m_wa;
    logic [1:0] m_tw;

    iss_t exp_iss[$];
    wr_t  exp_wr[$];
    int   exp_done[$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    logic prev_mul = 1'b0;
    iss_t mi;
    wr_t  mw;
    int   md;
    int   c0, a, r2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_seq_ctrl #(.LOG2N(3), .LAT(6), .GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .ena_fft_core(core0), .ena_mul_fp_clk(mul0), .ena_add_fp_clk(add0),
        .rd_addr_x(x0), .rd_addr_y(y0), .tw_addr(tw0), .w_neg(wneg0),
        .rd_bank(bank0), .wr_en(wr0), .wr_addr(wa0), .busy(busy0), .done(done0)
    );

    fft_seq_ctrl #(.LOG2N(3), .LAT(1), .GAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .ena_fft_core(core1), .ena_mul_fp_clk(mul1), .ena_add_fp_clk(add1),
        .rd_addr_x(x1), .rd_addr_y(y1), .tw_addr(tw1), .w_neg(wneg1),
        .rd_bank(bank1), .wr_en(wr1), .wr_addr(wa1), .busy(busy1), .done(done1)
    );

    always_comb begin
        m_core = sel ? core1 : core0;
        m_mul  = sel ? mul1  : mul0;
        m_add  = sel ? add1  : add0;
        m_wneg = sel ? wneg1 : wneg0;
        m_bank = sel ? bank1 : bank0;
        m_wr   = sel ? wr1   : wr0;
        m_busy = sel ? busy1 : busy0;
        m_done = sel ? done1 : done0;
        m_x    = sel ? x1    : x0;
        m_y    = sel ? y1    : y0;
        m_wa   = sel ? wa1   : wa0;
        m_tw   = sel ? tw1   : tw0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected issues, writes and done for a transform started at cycle c0, truncated after cycle 'last'.
    task automatic push_transform(input int start_cyc, input int gap, input int lat, input int last);
        int   per, ic;
        iss_t e;
        wr_t  w;
        per = 8 * gap + (lat - gap) + 1;
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                for (int p = 0; p < 2; p++) begin
                    ic = start_cyc + 1 + s * per + (2 * b + p) * gap;
                    if (ic <= last) begin
                        e.cyc = ic; e.x = tx[s][b]; e.y = ty[s][b]; e.tw = ttw[s][b];
                        e.wneg = p; e.bank = s % 2;
                        exp_iss.push_back(e);
                    end
                    if (ic + lat <= last) begin
                        w.cyc  = ic + lat;
                        w.addr = (p == 1) ? ty[s][b] : tx[s][b];
                        exp_wr.push_back(w);
                    end
                end
            end
        end
        if (start_cyc + 1 + 3 * per <= last) exp_done.push_back(start_cyc + 1 + 3 * per);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic check_drained(input int wr_expected);
        check("issues_left", exp_iss.size(), 0);
        check("writes_left", exp_wr.size(), 0);
        check("done_left", exp_done.size(), 0);
        check("wr_count", wr_cnt, wr_expected);
    endtask

    task automatic check_all_zero();
        check("zero_core", int'(m_core), 0);
        check("zero_mul", int'(m_mul), 0);
        check("zero_add", int'(m_add), 0);
        check("zero_x", int'(m_x), 0);
        check("zero_y", int'(m_y), 0);
        check("zero_tw", int'(m_tw), 0);
        check("zero_wneg", int'(m_wneg), 0);
        check("zero_bank", int'(m_bank), 0);
        check("zero_wr", int'(m_wr), 0);
        check("zero_wa", int'(m_wa), 0);
        check("zero_busy", int'(m_busy), 0);
        check("zero_done", int'(m_done), 0);
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT presents an issue, write or done.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mul = 1'b0;
        end else begin
            check("ena_add_delay", int'(m_add), int'(prev_mul));
            prev_mul = m_mul;
            if (m_mul) begin
                if (exp_iss.size() == 0) begin
                    check("issue_unexpected", int'(m_mul), 0);
                end else begin
                    mi = exp_iss.pop_front();
                    check("issue_cycle", cyc, mi.cyc);
                    check("rd_addr_x", int'(m_x), mi.x);
                    check("rd_addr_y", int'(m_y), mi.y);
                    check("tw_addr", int'(m_tw), mi.tw);
                    check("w_neg", int'(m_wneg), mi.wneg);
                    check("rd_bank", int'(m_bank), mi.bank);
                    check("issue_core_en", int'(m_core), 1);
                end
            end
            if (m_wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", int'(m_wr), 0);
                end else begin
                    mw = exp_wr.pop_front();
                    check("wr_cycle", cyc, mw.cyc);
                    check("wr_addr", int'(m_wa), mw.addr);
                end
            end
            if (m_done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", int'(m_done), 0);
                end else begin
                    md = exp_done.pop_front();
                    check("done_cycle", cyc, md);
                    check("done_core_off", int'(m_core), 0);
                    check("done_busy", int'(m_busy), 1);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero();

        // Full transform; a second start mid-transform must be ignored.
        wr_cnt = 0;
        c0 = cyc;
        push_transform(c0, 2, 6, BIG);
        pulse_start0();
        wait_until(c0 + 10);
        pulse_start0();
        wait_until(c0 + 70);
        check("t1_bank_hold", int'(m_bank), 0);
        check("t1_idle", int'(m_busy), 0);
        check_drained(24);

        // Abort during the drain of stage 1.
        wr_cnt = 0;
        c0 = cyc;
        a  = c0 + 39;
        push_transform(c0, 2, 6, a);
        pulse_start0();
        wait_until(a);
        check("pre_abort_busy", int'(m_busy), 1);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("abort_busy", int'(m_busy), 0);
        check("abort_core", int'(m_core), 0);
        check("abort_wr", int'(m_wr), 0);
        wait_until(a + 40);
        check_drained(14);

        // Restart after abort begins again at stage 0, bank 0.
        wr_cnt = 0;
        c0 = cyc;
        push_transform(c0, 2, 6, BIG);
        pulse_start0();
        wait_until(c0 + 70);
        check_drained(24);

        // Asynchronous reset in the middle of stage 0 issue.
        wr_cnt = 0;
        c0 = cyc;
        push_transform(c0, 2, 6, c0 + 6);
        pulse_start0();
        wait_until(c0 + 3);
        pulse_start0();
        wait_until(c0 + 6);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", int'(m_busy), 0);
        r2 = cyc;
        wait_until(r2 + 20);
        check_drained(0);

        // GAP=1, LAT=1 corner on the second instance.
        sel = 1'b1;
        @(negedge clk);
        wr_cnt = 0;
        c0 = cyc;
        push_transform(c0, 1, 1, BIG);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(c0 + 40);
        check_drained(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
